// File: rtl/game_pkg.sv
// Shared game constants: sprite geometry, play-field limits and the Tom FSM state type.
// Play-field limits are derived from a 1024x768 screen.
package game_pkg;

    localparam int TOM_WIDTH  = 30;
    localparam int TOM_HEIGHT = 64;
    localparam int X_LIMIT    = 1024 - TOM_WIDTH;
    localparam int Y_LIMIT    = 768 - TOM_HEIGHT;
    localparam int VY_W       = 6;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } tom_state_e;

endpackage

// File: rtl/tom_ctl.sv
// Tom movement controller: once per frame (vblnk rising edge), applies horizontal
// key motion and a simple ballistic jump.
module tom_ctl
    import game_pkg::*;
#(
    parameter int X_INIT  = 100,
    parameter int SPEED   = 4,
    parameter int JUMP_V0 = 16,
    parameter int GRAVITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [9:0] tom_x,
    output logic [9:0] tom_y,
    output logic       airborne,
    output logic       facing_left
);

    localparam logic [10:0]     SPEED_W = 11'(SPEED);
    localparam logic [10:0]     X_LIM_W = 11'(X_LIMIT);
    localparam logic [10:0]     Y_LIM_W = 11'(Y_LIMIT);
    localparam logic [9:0]      X_RST   = 10'(X_INIT);
    localparam logic [VY_W-1:0] VY_V0   = VY_W'(JUMP_V0);
    localparam logic [VY_W-1:0] GRAV_V  = VY_W'(GRAVITY);

    tom_state_e      state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [VY_W-1:0] vy_q, vy_d;
    logic            face_q, face_d;
    logic            pend_q, pend_d;
    logic            vblnk_q;

    logic            tick;
    logic            jump_now;
    logic [10:0]     x_sum;
    logic [10:0]     y_sum;
    logic [VY_W-1:0] vy_n;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        face_d   = face_q;
        pend_d   = pend_q | jump;
        tick     = vblnk & ~vblnk_q;
        jump_now = pend_q | jump;
        x_sum    = {1'b0, x_q} + SPEED_W;
        y_sum    = {1'b0, y_q} + 11'(vy_q);
        vy_n     = vy_q + GRAV_V;

        if (tick) begin
            // A jump arriving on the tick cycle is consumed by this tick.
            pend_d = 1'b0;

            if (left && !right) begin
                face_d = 1'b1;
                x_d    = ({1'b0, x_q} < SPEED_W) ? '0 : x_q - SPEED_W[9:0];
            end else if (right && !left) begin
                face_d = 1'b0;
                x_d    = (x_sum > X_LIM_W) ? X_LIM_W[9:0] : x_sum[9:0];
            end

            unique case (state_q)
                GROUND: begin
                    if (jump_now) begin
                        state_d = RISING;
                        vy_d    = VY_V0;
                    end else begin
                        y_d = '0;
                    end
                end
                RISING: begin
                    y_d = (y_sum > Y_LIM_W) ? Y_LIM_W[9:0] : y_sum[9:0];
                    if (vy_q <= GRAV_V || y_sum >= Y_LIM_W) begin
                        state_d = FALLING;
                        vy_d    = '0;
                    end else begin
                        vy_d = vy_q - GRAV_V;
                    end
                end
                FALLING: begin
                    if (y_q <= 10'(vy_n)) begin
                        state_d = GROUND;
                        y_d     = '0;
                        vy_d    = '0;
                    end else begin
                        y_d  = y_q - 10'(vy_n);
                        vy_d = vy_n;
                    end
                end
                default: begin
                    state_d = GROUND;
                    y_d     = '0;
                    vy_d    = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GROUND;
            x_q     <= X_RST;
            y_q     <= '0;
            vy_q    <= '0;
            face_q  <= 1'b0;
            pend_q  <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            face_q  <= face_d;
            pend_q  <= pend_d;
            vblnk_q <= vblnk;
        end
    end

    assign tom_x       = x_q;
    assign tom_y       = y_q;
    assign airborne    = (state_q != GROUND);
    assign facing_left = face_q;

endmodule

// File: tb/tb_tom_ctl.sv
// Self-checking bench for tom_ctl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a frame-level behavioural model.
module tb_tom_ctl;
    import game_pkg::*;

    localparam int XI = 100;
    localparam int SP = 4;
    localparam int V0 = 16;
    localparam int GR = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       jump = 1'b0;
    logic [9:0] tom_x;
    logic [9:0] tom_y;
    logic       airborne;
    logic       facing_left;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    tom_ctl #(.X_INIT(XI), .SPEED(SP), .JUMP_V0(V0), .GRAVITY(GR)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .left(left), .right(right), .jump(jump),
        .tom_x(tom_x), .tom_y(tom_y), .airborne(airborne), .facing_left(facing_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: one update per vblnk rise, airborne phases as plain integers.
    typedef struct {
        int x;
        int y;
        int vy;
        int phase;  // 0 on floor, 1 going up, 2 coming down
        bit face;
        bit pend;
        bit vb;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.x = XI; s.y = 0; s.vy = 0; s.phase = 0;
        s.face = 0; s.pend = 0; s.vb = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit vb, bit l, bit r, bit j);
        mdl_t n = s;
        int   want;
        int   next_v;
        n.vb = vb;
        if (!(vb && !s.vb)) begin
            n.pend = s.pend | j;
            return n;
        end
        want   = (s.pend || j) ? 1 : 0;
        n.pend = 0;
        if (l && !r) begin
            n.face = 1;
            n.x    = (s.x - SP < 0) ? 0 : s.x - SP;
        end else if (r && !l) begin
            n.face = 0;
            n.x    = (s.x + SP > X_LIMIT) ? X_LIMIT : s.x + SP;
        end
        if (s.phase == 0) begin
            if (want != 0) begin
                n.phase = 1;
                n.vy    = V0;
            end else begin
                n.y = 0;
            end
        end else if (s.phase == 1) begin
            n.y = (s.y + s.vy > Y_LIMIT) ? Y_LIMIT : s.y + s.vy;
            if (s.vy <= GR || s.y + s.vy >= Y_LIMIT) begin
                n.phase = 2;
                n.vy    = 0;
            end else begin
                n.vy = s.vy - GR;
            end
        end else begin
            next_v = s.vy + GR;
            if (s.y <= next_v) begin
                n.y = 0; n.vy = 0; n.phase = 0;
            end else begin
                n.y  = s.y - next_v;
                n.vy = next_v;
            end
        end
        return n;
    endfunction

    mdl_t m;

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= mdl_reset();
        else      m <= mdl_step(m, vblnk, left, right, jump);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_x", int'(tom_x), m.x);
            check("model_y", int'(tom_y), m.y);
            check("model_airborne", int'(airborne), (m.phase != 0) ? 1 : 0);
            check("model_facing", int'(facing_left), int'(m.face));
        end
    end

    task automatic do_tick();
        @(posedge clk); #2 vblnk = 1'b1;
        @(posedge clk); #2 vblnk = 1'b0;
    endtask

    task automatic pulse_jump();
        @(posedge clk); #2 jump = 1'b1;
        @(posedge clk); #2 jump = 1'b0;
    endtask

    // Runs a jump already requested; returns peak height, height after the 17th tick and landing tick.
    task automatic run_jump(input bit repulse, output int peak, output int y17, output int land,
                            output int x_end);
        peak = 0; y17 = -1; land = 0;
        for (int t = 2; t <= 40; t++) begin
            if (repulse && (t == 5 || t == 20)) pulse_jump();
            do_tick();
            if (int'(tom_y) > peak) peak = int'(tom_y);
            if (t == 17) y17 = int'(tom_y);
            if (land == 0 && !airborne) land = t;
        end
        x_end = int'(tom_x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int peak, y17, land, x_end;

        repeat (3) @(posedge clk);
        #2 cmp_en = 1'b1;
        check("reset_x", int'(tom_x), 100);
        check("reset_y", int'(tom_y), 0);
        check("reset_airborne", int'(airborne), 0);
        check("reset_facing", int'(facing_left), 0);
        rst = 1'b1;

        right = 1'b1;
        do_tick(); check("right_tick1", int'(tom_x), 104);
        do_tick(); check("right_tick2", int'(tom_x), 108);
        do_tick(); check("right_tick3", int'(tom_x), 112);
        check("right_facing", int'(facing_left), 0);
        check("right_airborne", int'(airborne), 0);

        repeat (230) do_tick();
        check("right_saturate", int'(tom_x), 994);

        right = 1'b0; left = 1'b1;
        do_tick();
        check("left_first", int'(tom_x), 990);
        check("left_facing", int'(facing_left), 1);
        repeat (247) do_tick();
        check("left_at_2", int'(tom_x), 2);
        do_tick(); check("left_floor", int'(tom_x), 0);
        do_tick(); check("left_floor_hold", int'(tom_x), 0);
        check("left_facing_hold", int'(facing_left), 1);

        left = 1'b0; right = 1'b1;
        repeat (3) do_tick();
        check("prejump_x", int'(tom_x), 12);

        left = 1'b1;
        pulse_jump();
        repeat (3) @(posedge clk);
        do_tick();
        check("jump_air_tick1", int'(airborne), 1);
        check("jump_y_tick1", int'(tom_y), 0);
        run_jump(1'b0, peak, y17, land, x_end);
        check("jump_peak", peak, 136);
        check("jump_y_tick17", y17, 136);
        check("jump_land_tick", land, 33);
        check("both_keys_x", x_end, 12);
        check("both_keys_facing", int'(facing_left), 0);

        left = 1'b0; right = 1'b0;
        pulse_jump();
        do_tick();
        check("rejump_air_tick1", int'(airborne), 1);
        run_jump(1'b1, peak, y17, land, x_end);
        check("rejump_peak", peak, 136);
        check("rejump_y_tick17", y17, 136);
        check("rejump_land_tick", land, 33);
        check("rejump_no_relaunch", int'(airborne), 0);

        right = 1'b1;
        pulse_jump();
        repeat (10) do_tick();
        check("midjump_air", int'(airborne), 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_x", int'(tom_x), 100);
        check("async_rst_y", int'(tom_y), 0);
        check("async_rst_air", int'(airborne), 0);
        check("async_rst_facing", int'(facing_left), 0);
        @(posedge clk); #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("post_rst_x", int'(tom_x), 100);
        check("post_rst_y", int'(tom_y), 0);

        vblnk = 1'b1;
        repeat (10) @(posedge clk);
        #2 vblnk = 1'b0;
        check("held_vblnk_one_tick", int'(tom_x), 104);
        right = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 15) == 0) left  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) right = 1'($urandom_range(0, 1));
            jump  = ($urandom_range(0, 39) == 0);
            vblnk = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #2;
        jump = 1'b0; vblnk = 1'b0; left = 1'b0; right = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tom_ctl.md
TOM_CTL -- requirements
Module: tom_ctl

Interface
REQ-001 SHALL have parameter X_INIT, default 100, the Tom horizontal position after reset (pixels).
REQ-002 SHALL have parameter SPEED, default 4, the horizontal step per frame (pixels).
REQ-003 SHALL have parameter JUMP_V0, default 16, the initial vertical velocity of a jump (pixels/frame).
REQ-004 SHALL have parameter GRAVITY, default 1, the velocity change per frame (pixels/frame²).
REQ-005 SHALL have port clk, input, 1 bit: the single clock (65 MHz pixel clock).
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port vblnk, input, 1 bit: vertical blank from the VGA timing stream.
REQ-008 SHALL have ports left and right, input, 1 bit each: held-key levels.
REQ-009 SHALL have port jump, input, 1 bit: a jump request, possibly a single-cycle pulse.
REQ-010 SHALL have port tom_x, output, 10 bits: the left edge of Tom; this drives the draw stage.
REQ-011 SHALL have port tom_y, output, 10 bits: the height of Tom's feet above the floor; this drives the draw stage.
REQ-012 SHALL have port airborne, output, 1 bit: high while the state is not GROUND.
REQ-013 SHALL have port facing_left, output, 1 bit: the last horizontal direction pressed.

Function
REQ-014 SHALL detect the frame tick as a vblnk rising edge (registered vblnk was 0, current vblnk is 1); all position updates occur only on the cycle of the tick, with registered outputs valid on the next cycle.
REQ-015 SHALL latch jump into a pending flag on any cycle; the flag clears on a tick; a jump asserted on the tick cycle itself counts for that tick.
REQ-016 SHALL sample left and right as levels on the tick; both high or both low SHALL leave tom_x unchanged.
REQ-017 SHALL move as follows on left only: tom_x = max(tom_x - SPEED, 0), saturating without underflow, and facing_left = 1.
REQ-018 SHALL move as follows on right only: tom_x = min(tom_x + SPEED, X_LIMIT), and facing_left = 0.
REQ-019 SHALL implement a three-state FSM: GROUND, RISING, FALLING, using an internal unsigned velocity vy (6 bits minimum).
REQ-020 SHALL, in GROUND with pending jump at a tick, go to RISING and set vy = JUMP_V0, with tom_y unchanged that tick; otherwise tom_y = 0.
REQ-021 SHALL, in RISING at a tick, set tom_y = min(tom_y + vy, Y_LIMIT).
REQ-022 SHALL, in RISING, go to FALLING with vy = 0 if vy <= GRAVITY or the ceiling is hit; otherwise vy -= GRAVITY.
REQ-023 SHALL, in FALLING at a tick, compute vy_n = vy + GRAVITY; if tom_y <= vy_n then tom_y = 0, vy = 0, and the state goes to GROUND; otherwise tom_y -= vy_n and vy = vy_n.
REQ-024 SHALL ignore a pending jump while RISING or FALLING (no double jump); the flag is still cleared on the tick.
REQ-025 SHALL apply horizontal motion in every state, independent of vertical motion, on the same tick.
REQ-026 SHALL produce no update when there is no tick; a vblnk held high SHALL produce exactly one tick.

Reset
REQ-027 SHALL, while rst = 0 (asynchronous, including mid-jump), force tom_x = X_INIT, tom_y = 0, vy = 0, state GROUND, airborne = 0, facing_left = 0, pending flag = 0, and registered vblnk = 0.
REQ-028 SHALL generate no tick in the first cycle after reset release unless vblnk rises.

Structure
REQ-029 SHALL take TOM_WIDTH and TOM_HEIGHT from game_pkg, and SHALL add X_LIMIT = 1024 - TOM_WIDTH, Y_LIMIT = 768 - TOM_HEIGHT, and the FSM state enum there.
REQ-030 SHALL be a single module with no sub-modules; the edge detector is inline.

Verification
REQ-031 SHALL cover: reset, then 3 ticks with right held -> tom_x = 100, 104, 108, 112; facing_left = 0; airborne = 0.
REQ-032 SHALL cover: tom_x = 2, left held for 1 tick -> tom_x = 0; another tick -> tom_x stays 0; facing_left = 1.
REQ-033 SHALL cover: a 1-cycle jump pulse mid-frame, then ticks -> airborne after tick 1; tom_y peaks at 136 after 16 ticks; tom_y = 0 and GROUND after 32 ticks.
REQ-034 SHALL cover: a jump pulse while airborne -> trajectory identical to REQ-033, with no re-launch.
REQ-035 SHALL cover: left and right held together during a jump -> tom_x constant while tom_y follows REQ-033.
REQ-036 SHALL cover: rst = 0 asserted at tick 10 of a jump -> outputs immediately at reset values; after release, no movement until the next vblnk rise.
